alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter ILLEGAL_TRAP, default 1, selecting trap-and-halt on an undecodable instruction (1) or silent discard (0).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port inst_valid  input  1  instruction word offered.
REQ-005 The block SHALL have port inst  input  32  LA32R instruction word.
REQ-006 The block SHALL have port inst_ready  output  1  block accepts inst this cycle.
REQ-007 The block SHALL have port alu_src0 / alu_src1  output  32 each  registered ALU operands.
REQ-008 The block SHALL have port alu_op  output  4  registered ALU op code.
REQ-009 The block SHALL have port alu_res  input  32  combinational ALU result for current alu_src0/alu_src1/alu_op.
REQ-010 The block SHALL have ports done  output  1, done_rd  output  5, done_data  output  32  retirement report.
REQ-011 The block SHALL have port err  output  1  sticky illegal-instruction flag.
REQ-012 The block SHALL have ports dbg_addr  input  5 and dbg_data  output  32  combinational register-file read.

Function
REQ-013 The block SHALL hold a 32x32 register file; r0 SHALL read 0 and ignore writes.
REQ-014 The block SHALL decode inst[31:15]: 0x00020 add.w->op 0x0, 0x00022 sub.w->0x1, 0x00024 slt->0x2, 0x00025 sltu->0x3, 0x00029 and->0x4, 0x0002A or->0x5, 0x00028 nor->0x6, 0x0002B xor->0x7, 0x0002E sll.w->0x8, 0x0002F srl.w->0x9, 0x00030 sra.w->0xA.
REQ-015 For those, the block SHALL use rd=inst[4:0], src0=R[inst[9:5]], src1=R[inst[14:10]].
REQ-016 inst[31:25]=7'b0001010 (lu12i.w) SHALL give op 0xB, src0=0, src1={inst[24:5],12'h000}, rd=inst[4:0].
REQ-017 Any other word SHALL be illegal.
REQ-018 FSM states: IDLE, DEC, EXE, WB, HALT; inst_ready=1 only in IDLE.
REQ-019 IDLE: handshake (inst_valid & inst_ready) at edge E0 SHALL latch inst and go DEC; otherwise stay.
REQ-020 DEC: at E1, legal -> load alu_src0/alu_src1/alu_op, go EXE; illegal with ILLEGAL_TRAP=1 -> err=1, go HALT; illegal with ILLEGAL_TRAP=0 -> go IDLE, no done, no write, ALU outputs unchanged.
REQ-021 EXE: at E2 the block SHALL write alu_res to R[rd] (unless rd=0), load done_rd=rd and done_data=alu_res, go WB.
REQ-022 WB: done SHALL be 1 for exactly this one cycle; at E3 go IDLE.
REQ-023 Latency: handshake to done = 3 cycles; throughput one instruction per 4 cycles.
REQ-024 done_rd/done_data SHALL hold their value until the next retirement; done_data SHALL equal alu_res even when rd=0.
REQ-025 An instruction reading the rd written by the previous instruction SHALL see the new value (write at E2 precedes next DEC).
REQ-026 HALT: inst_ready=0, err=1, no further state change until reset.
REQ-027 dbg_data SHALL reflect R[dbg_addr] combinationally, including a write on the preceding edge.
REQ-028 inst and inst_valid SHALL be ignored outside IDLE.

Reset
REQ-029 With rstn=0 at an edge: state IDLE, all registers 0, alu_src0/alu_src1=0, alu_op=0x0, done=0, done_rd=0, done_data=0, err=0; inst_ready SHALL read 0 while rstn=0.
REQ-030 Reset in DEC/EXE/WB SHALL abort the instruction: no register write, no done pulse.
REQ-031 First cycle with rstn=1 SHALL show inst_ready=1.

Verification
REQ-032 lu12i.w r1,0x12345 then lu12i.w r2,0x00001, add.w r3,r1,r2 -> done_rd=3, done_data=0x12346000, 3 cycles after handshake.
REQ-033 R1=0xFFFFFFFF,R2=1: slt r4,r1,r2 -> 1; sltu r5,r1,r2 -> 0; sub.w r6,r2,r1 -> 0x00000002.
REQ-034 R1=0x80000000,R2=4: sra.w -> 0xF8000000; srl.w -> 0x08000000; sll.w r7,r2,r2 -> 0x00000040; alu_op observed 0xA/0x9/0x8.
REQ-035 add.w r0,r1,r1 with R1=5 -> done=1, done_data=0x0000000A, dbg_addr=0 reads 0.
REQ-036 inst=0xFFFFFFFF: ILLEGAL_TRAP=1 -> err=1, inst_ready stays 0 until rstn=0; ILLEGAL_TRAP=0 -> no done, inst_ready=1 two cycles after handshake.
REQ-037 rstn=0 during EXE of add.w r8 -> R8 reads 0, no done, inst_ready=1 first cycle after release.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer for the LA32R 3-register ALU subset and
// lu12i.w. Each instruction walks IDLE -> DEC -> EXE -> WB; the ALU itself is
// external and combinational, fed from the registered operand/op outputs.
//
// Ports
//   clk         sole clock, rising edge
//   rstn        synchronous active-low reset
//   inst_valid  instruction offered
//   inst        32-bit instruction word
//   inst_ready  block accepts inst this cycle (IDLE only, low during reset)
//   alu_src0/1  registered ALU operands
//   alu_op      registered ALU op code
//   alu_res     combinational ALU result for the current operands/op
//   done        one-cycle retirement strobe
//   done_rd     destination of the last retired instruction
//   done_data   result of the last retired instruction
//   err         sticky illegal-instruction flag
//   dbg_addr    register-file debug read address
//   dbg_data    register-file debug read data (combinational)
//
// Parameter ILLEGAL_TRAP: 1 = halt on an undecodable word, 0 = discard it.
module alu_issue #(
  parameter int unsigned ILLEGAL_TRAP = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [31:0] alu_src0,
  output logic [31:0] alu_src1,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic        done,
  output logic [4:0]  done_rd,
  output logic [31:0] done_data,
  output logic        err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DEC  = 3'd1,
    EXE  = 3'd2,
    WB   = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] inst_q;
  logic [31:0] regs [32];

  logic        dec_legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_src0;
  logic [31:0] dec_src1;
  logic [4:0]  rd;

  assign rd = inst_q[4:0];

  // r0 is never written, but reads are forced to zero as well so the debug
  // port and operand path cannot expose a stale value.
  function automatic logic [31:0] rf_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : regs[a];
  endfunction

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = 4'h0;
    dec_src0  = rf_read(inst_q[9:5]);
    dec_src1  = rf_read(inst_q[14:10]);
    case (inst_q[31:15])
      17'h00020: dec_op = 4'h0;
      17'h00022: dec_op = 4'h1;
      17'h00024: dec_op = 4'h2;
      17'h00025: dec_op = 4'h3;
      17'h00029: dec_op = 4'h4;
      17'h0002A: dec_op = 4'h5;
      17'h00028: dec_op = 4'h6;
      17'h0002B: dec_op = 4'h7;
      17'h0002E: dec_op = 4'h8;
      17'h0002F: dec_op = 4'h9;
      17'h00030: dec_op = 4'hA;
      default:   dec_legal = 1'b0;
    endcase
    // lu12i.w occupies a disjoint major-opcode space, so it never collides
    // with the 3R table above.
    if (inst_q[31:25] == 7'b0001010) begin
      dec_legal = 1'b1;
      dec_op    = 4'hB;
      dec_src0  = 32'h0;
      dec_src1  = {inst_q[24:5], 12'h000};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (inst_valid) state_nxt = DEC;
      DEC: begin
        if (dec_legal)              state_nxt = EXE;
        else if (ILLEGAL_TRAP != 0) state_nxt = HALT;
        else                        state_nxt = IDLE;
      end
      EXE:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      inst_q    <= 32'h0;
      alu_src0  <= 32'h0;
      alu_src1  <= 32'h0;
      alu_op    <= 4'h0;
      done_rd   <= 5'd0;
      done_data <= 32'h0;
      err       <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && inst_valid) inst_q <= inst;
      if (state == DEC) begin
        if (dec_legal) begin
          alu_src0 <= dec_src0;
          alu_src1 <= dec_src1;
          alu_op   <= dec_op;
        end else if (ILLEGAL_TRAP != 0) begin
          err <= 1'b1;
        end
      end
      if (state == EXE) begin
        if (rd != 5'd0) regs[rd] <= alu_res;
        done_rd   <= rd;
        done_data <= alu_res;
      end
    end
  end

  assign inst_ready = rstn && (state == IDLE);
  assign done       = (state == WB);
  assign dbg_data   = rf_read(dbg_addr);

endmodule
